nvram_upload: RTL and testbench

- Serves HPS-initiated uploads (save direction) of game work RAM, for high-score/NVRAM saving.
- Complements the existing ROM/DIP download path: instead of accepting ioctl writes, it answers ioctl read strobes with bytes fetched from a second port of the game RAM.
- Pauses the game CPU for the duration of the transfer so the saved image is coherent.
- Sits in the emu top between hps_io and the game core's RAM port B.

---
 rtl/nvram_upload.sv | 130 +++++++++++++
 tb/tb_nvram_upload.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload.sv
// Serves HPS save-direction ioctl reads from game RAM port B, pausing the game CPU
// for the whole session so the uploaded image is coherent.
//
//   state | meaning
//   IDLE  | no session; outputs inactive
//   PAUSE | pause_req held, waiting for pause_ack; early reads are latched as pending
//   READY | CPU halted, port B owned, waiting for a read strobe
//   FETCH | RAM read in flight, down-counting RAM_LATENCY cycles
module nvram_upload #(
  parameter int ADDR_WIDTH   = 10,
  parameter int SAVE_SIZE    = 1024,
  parameter int UPLOAD_INDEX = 4,
  parameter int RAM_LATENCY  = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ioctl_upload,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_rd,
  input  logic [24:0]           ioctl_addr,
  output logic [7:0]            ioctl_din,
  output logic                  ioctl_wait,
  output logic                  pause_req,
  input  logic                  pause_ack,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd,
  input  logic [7:0]            ram_q,
  output logic                  busy,
  output logic [15:0]           bytes_sent
);

  typedef enum logic [1:0] {IDLE, PAUSE, READY, FETCH} state_t;

  localparam logic [24:0] SAVE_LIM = 25'(SAVE_SIZE);
  localparam logic [1:0]  LAT_LOAD = 2'(RAM_LATENCY - 1);
  localparam logic [7:0]  IDX      = 8'(UPLOAD_INDEX);

  state_t      state;
  logic        upload_q;
  logic        pend;
  logic [24:0] pend_addr;
  logic [1:0]  lat_cnt;

  logic        start;
  logic        req;
  logic [24:0] req_addr;
  logic        req_in_range;
  logic        rd_in_range;

  assign start        = ioctl_upload && !upload_q && (ioctl_index == IDX);
  assign req          = ioctl_rd || pend;
  assign req_addr     = ioctl_rd ? ioctl_addr : pend_addr;
  // Full 25-bit compare so high address bits can never alias into RAM.
  assign req_in_range = req_addr < SAVE_LIM;
  assign rd_in_range  = ioctl_addr < SAVE_LIM;

  assign busy       = (state != IDLE);
  assign ioctl_wait = ((state == PAUSE) && ioctl_upload) ||
                      (state == FETCH) ||
                      (ioctl_rd && (state == READY) && rd_in_range);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      upload_q   <= 1'b0;
      pend       <= 1'b0;
      pend_addr  <= '0;
      lat_cnt    <= '0;
      ioctl_din  <= 8'hFF;
      pause_req  <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      bytes_sent <= '0;
    end else begin
      upload_q <= ioctl_upload;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= PAUSE;
            pause_req  <= 1'b1;
            bytes_sent <= '0;
          end
        end
        PAUSE, READY: begin
          if (!ioctl_upload) begin
            state     <= IDLE;
            pause_req <= 1'b0;
            ram_rd    <= 1'b0;
            pend      <= 1'b0;
          end else if ((state == PAUSE) && !pause_ack) begin
            if (ioctl_rd) begin
              pend      <= 1'b1;
              pend_addr <= ioctl_addr;
            end
          end else if (req) begin
            // A pending read is served on the ack cycle itself, saving one cycle.
            pend <= 1'b0;
            if (req_in_range) begin
              ram_addr <= req_addr[ADDR_WIDTH-1:0];
              ram_rd   <= 1'b1;
              lat_cnt  <= LAT_LOAD;
              state    <= FETCH;
            end else begin
              ioctl_din <= 8'hFF;
              state     <= READY;
            end
          end else begin
            state <= READY;
          end
        end
        FETCH: begin
          if (!ioctl_upload) begin
            state     <= IDLE;
            pause_req <= 1'b0;
            ram_rd    <= 1'b0;
            pend      <= 1'b0;
          end else if (lat_cnt == 2'd0) begin
            ioctl_din <= ram_q;
            if (bytes_sent != 16'hFFFF) bytes_sent <= bytes_sent + 16'd1;
            state <= READY;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_upload.sv
// Directed bench for nvram_upload: one instance at RAM_LATENCY 1 and one at 3,
// sharing HPS-side stimulus, each with its own port-B RAM model.
module tb_nvram_upload;

  logic        clk = 1'b0;
  logic        RESET;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic        pause_ack;

  logic [7:0]  din1, din3;
  logic        wait1, wait3, preq1, preq3, rrd1, rrd3, busy1, busy3;
  logic [9:0]  raddr1, raddr3;
  logic [7:0]  q1, q3;
  logic [15:0] nb1, nb3;

  logic [7:0]  mem [0:1023];
  logic [7:0]  p0, p1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nvram_upload #(.ADDR_WIDTH(10), .SAVE_SIZE(1024), .UPLOAD_INDEX(4), .RAM_LATENCY(1)) u_dut1 (
    .CLK(clk), .RESET(RESET), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din1), .ioctl_wait(wait1),
    .pause_req(preq1), .pause_ack(pause_ack), .ram_addr(raddr1), .ram_rd(rrd1),
    .ram_q(q1), .busy(busy1), .bytes_sent(nb1));

  nvram_upload #(.ADDR_WIDTH(10), .SAVE_SIZE(1024), .UPLOAD_INDEX(4), .RAM_LATENCY(3)) u_dut3 (
    .CLK(clk), .RESET(RESET), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din3), .ioctl_wait(wait3),
    .pause_req(preq3), .pause_ack(pause_ack), .ram_addr(raddr3), .ram_rd(rrd3),
    .ram_q(q3), .busy(busy3), .bytes_sent(nb3));

  // Latency-1 RAM returns data in the address cycle; latency-3 RAM has two register stages.
  assign q1 = mem[raddr1];
  always @(posedge clk) begin
    p0 <= mem[raddr3];
    p1 <= p0;
  end
  assign q3 = p1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_byte(input logic [24:0] a, input logic [7:0] exp_d, input logic [15:0] exp_n);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    #1;
    check_val("wait_on_strobe", 32'(wait1), 32'd1);
    tick();
    ioctl_rd = 1'b0;
    check_val("ram_addr", 32'(raddr1), 32'(a[9:0]));
    check_val("wait_in_fetch", 32'(wait1), 32'd1);
    tick();
    check_val("din", 32'(din1), 32'(exp_d));
    check_val("wait_done", 32'(wait1), 32'd0);
    check_val("bytes_sent", 32'(nb1), 32'(exp_n));
  endtask

  task automatic oor_read(input logic [24:0] a, input logic [9:0] exp_addr, input logic [15:0] exp_n);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    #1;
    check_val("oor_wait", 32'(wait1), 32'd0);
    tick();
    ioctl_rd = 1'b0;
    check_val("oor_din", 32'(din1), 32'hFF);
    check_val("oor_ram_addr", 32'(raddr1), 32'(exp_addr));
    check_val("oor_bytes", 32'(nb1), 32'(exp_n));
    check_val("oor_ram_rd", 32'(rrd1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i + 16);
    RESET = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
    ioctl_addr = '0; pause_ack = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    check_val("rst_din", 32'(din1), 32'hFF);
    check_val("rst_wait", 32'(wait1), 32'd0);
    check_val("rst_preq", 32'(preq1), 32'd0);
    check_val("rst_ram_addr", 32'(raddr1), 32'd0);
    check_val("rst_ram_rd", 32'(rrd1), 32'd0);
    check_val("rst_busy", 32'(busy1), 32'd0);
    check_val("rst_bytes", 32'(nb1), 32'd0);

    // Basic save, ack after 5 cycles
    ioctl_index = 8'd4; ioctl_upload = 1'b1;
    tick();
    check_val("start_preq", 32'(preq1), 32'd1);
    check_val("start_busy", 32'(busy1), 32'd1);
    check_val("pause_wait", 32'(wait1), 32'd1);
    check_val("start_bytes", 32'(nb1), 32'd0);
    repeat (4) tick();
    pause_ack = 1'b1;
    tick();
    check_val("ready_wait", 32'(wait1), 32'd0);
    for (int i = 0; i < 4; i++) read_byte(25'(i), 8'(16 + i), 16'(i + 1));
    check_val("basic_preq", 32'(preq1), 32'd1);

    // Boundary and out-of-range addresses
    read_byte(25'h3FF, 8'h0F, 16'd5);
    oor_read(25'h400, 10'h3FF, 16'd5);
    read_byte(25'd2, 8'h12, 16'd6);
    oor_read(25'h1000000, 10'd2, 16'd6);

    ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick();
    check_val("end_preq", 32'(preq1), 32'd0);
    check_val("end_ram_rd", 32'(rrd1), 32'd0);
    check_val("end_busy", 32'(busy1), 32'd0);

    // Early read while paused
    ioctl_upload = 1'b1;
    tick();
    check_val("early_bytes_clr", 32'(nb1), 32'd0);
    ioctl_rd = 1'b1; ioctl_addr = 25'd7;
    tick();
    ioctl_rd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_val("early_wait", 32'(wait1), 32'd1);
      tick();
    end
    pause_ack = 1'b1;
    tick();
    check_val("early_ram_addr", 32'(raddr1), 32'd7);
    check_val("early_wait_fetch", 32'(wait1), 32'd1);
    tick();
    check_val("early_din", 32'(din1), 32'h17);
    check_val("early_wait_done", 32'(wait1), 32'd0);
    check_val("early_bytes", 32'(nb1), 32'd1);
    ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick();

    // Wrong index, including index change while upload held high
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    ioctl_index = 8'd0; ioctl_upload = 1'b1; pause_ack = 1'b1;
    tick();
    check_val("wi0_preq", 32'(preq1), 32'd0);
    check_val("wi0_busy", 32'(busy1), 32'd0);
    ioctl_rd = 1'b1; ioctl_addr = 25'd1;
    #1;
    check_val("wi0_wait", 32'(wait1), 32'd0);
    tick();
    ioctl_rd = 1'b0;
    tick();
    check_val("wi0_ram_rd", 32'(rrd1), 32'd0);
    check_val("wi0_din", 32'(din1), 32'hFF);
    ioctl_index = 8'd4;
    tick(); tick();
    check_val("wi_no_edge_busy", 32'(busy1), 32'd0);
    ioctl_upload = 1'b0;
    tick();
    ioctl_index = 8'd254; ioctl_upload = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'd2;
    tick();
    ioctl_rd = 1'b0;
    tick();
    check_val("wi254_preq", 32'(preq1), 32'd0);
    check_val("wi254_ram_rd", 32'(rrd1), 32'd0);
    check_val("wi254_din", 32'(din1), 32'hFF);
    ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick();

    // Latency 3 fetch, then abort mid-fetch
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    ioctl_index = 8'd4; ioctl_upload = 1'b1;
    tick();
    pause_ack = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    tick();
    ioctl_rd = 1'b0;
    tick(); tick();
    check_val("l3_din_not_yet", 32'(din3), 32'hFF);
    check_val("l3_wait_fetch", 32'(wait3), 32'd1);
    tick();
    check_val("l3_din", 32'(din3), 32'h15);
    check_val("l3_bytes", 32'(nb3), 32'd1);
    check_val("l3_wait_done", 32'(wait3), 32'd0);
    ioctl_rd = 1'b1; ioctl_addr = 25'd6;
    tick();
    ioctl_rd = 1'b0;
    tick();
    check_val("abort_pre_busy", 32'(busy3), 32'd1);
    ioctl_upload = 1'b0;
    tick();
    check_val("abort_preq", 32'(preq3), 32'd0);
    check_val("abort_ram_rd", 32'(rrd3), 32'd0);
    check_val("abort_busy", 32'(busy3), 32'd0);
    check_val("abort_din", 32'(din3), 32'h15);
    check_val("abort_bytes", 32'(nb3), 32'd1);
    pause_ack = 1'b0;
    tick();

    // Reset mid-session, then clean restart
    ioctl_upload = 1'b1;
    tick();
    pause_ack = 1'b1;
    tick();
    read_byte(25'd3, 8'h13, 16'd1);
    RESET = 1'b1; ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick();
    RESET = 1'b0;
    check_val("mrst_din", 32'(din1), 32'hFF);
    check_val("mrst_preq", 32'(preq1), 32'd0);
    check_val("mrst_busy", 32'(busy1), 32'd0);
    check_val("mrst_bytes", 32'(nb1), 32'd0);
    check_val("mrst_ram_rd", 32'(rrd1), 32'd0);
    check_val("mrst_ram_addr", 32'(raddr1), 32'd0);
    ioctl_upload = 1'b1;
    tick();
    check_val("restart_preq", 32'(preq1), 32'd1);
    check_val("restart_bytes", 32'(nb1), 32'd0);
    pause_ack = 1'b1;
    tick();
    read_byte(25'd1, 8'h11, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
